router_input_port: RTL and testbench

//  Clocked router input stage; sits directly upstream of the 5-input output arbiters.

---
 rtl/noc_pkg.sv | 54 +++++
 rtl/router_input_port_if.sv | 26 ++
 rtl/noc_sync_fifo.sv | 68 ++++++
 rtl/router_input_port.sv | 83 ++++++++
 tb/tb_router_input_port.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC types, default flit layout and XY route function
// Used by the router input ports and the downstream output arbiters.
package noc_pkg;

  localparam int NUM_DIRS = 5;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_S = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  typedef struct packed {
    logic err;
    dir_e dir;
  } route_t;

  // Default flit layout {dst_x, dst_y, payload}, MSB first
  localparam int COORD_W_DEF   = 2;
  localparam int PAYLOAD_W_DEF = 7;
  localparam int FLIT_W_DEF    = 2 * COORD_W_DEF + PAYLOAD_W_DEF;
  localparam int DST_X_MSB_DEF = FLIT_W_DEF - 1;
  localparam int DST_Y_MSB_DEF = FLIT_W_DEF - COORD_W_DEF - 1;
  localparam int PAYLOAD_MSB_DEF = PAYLOAD_W_DEF - 1;

  // Dimension-ordered routing: resolve X first, then Y, then eject locally
  function automatic route_t xy_route(
    input logic [31:0] dst_x,
    input logic [31:0] dst_y,
    input logic [31:0] my_x,
    input logic [31:0] my_y,
    input logic [31:0] mesh_x,
    input logic [31:0] mesh_y
  );
    route_t r;
    r.err = 1'b0;
    r.dir = DIR_L;
    if (dst_x >= mesh_x || dst_y >= mesh_y) begin
      r.err = 1'b1;
    end else if (dst_x > my_x) begin
      r.dir = DIR_E;
    end else if (dst_x < my_x) begin
      r.dir = DIR_W;
    end else if (dst_y > my_y) begin
      r.dir = DIR_N;
    end else if (dst_y < my_y) begin
      r.dir = DIR_S;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// rtl/router_input_port_if.sv - link-side and arbiter-side handshake bundle
// slave is the input port's view, master is the upstream/arbiter side.
interface router_input_port_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = 11
) ();

  logic                in_valid;
  logic                in_ready;
  logic [FLIT_W-1:0]   in_data;
  logic [NUM_DIRS-1:0] out_valid;
  logic [NUM_DIRS-1:0] out_ready;
  logic [FLIT_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - single-clock FIFO with occupancy count
// No bypass: a push into an empty FIFO is visible on rdata after the edge.
module noc_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= (PTR_W+1)'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full));

endmodule

// File: rtl/router_input_port.sv
// rtl/router_input_port.sv - buffered router input with XY route decode
// Head flit requests exactly one direction; out-of-mesh heads are dropped and flagged.
module router_input_port
  import noc_pkg::*;
#(
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  router_input_port_if.slave     port,
  output logic                   route_err,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int FLIT_W = 2 * COORD_W + PAYLOAD_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                fifo_push, fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [FLIT_W-1:0]   head;
  logic [CNT_W-1:0]    count;
  logic [COORD_W-1:0]  head_x, head_y;
  route_t              route;
  logic                head_err;
  logic [NUM_DIRS-1:0] req;
  logic                route_err_q, route_err_d;

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (port.in_data),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign head_x = head[FLIT_W-1 -: COORD_W];
  assign head_y = head[FLIT_W-COORD_W-1 -: COORD_W];

  always_comb begin
    route = xy_route(32'(head_x), 32'(head_y), 32'(MY_X), 32'(MY_Y),
                     32'(MESH_X), 32'(MESH_Y));
    head_err = !fifo_empty && route.err;
    req = '0;
    if (!fifo_empty && !route.err) begin
      req[route.dir] = 1'b1;
    end
    // Unselected out_ready bits are masked off by the one-hot request
    fifo_pop    = head_err || |(req & port.out_ready);
    route_err_d = route_err_q || head_err;
  end

  assign fifo_push      = port.in_valid && !fifo_full;
  assign port.in_ready  = !fifo_full;
  assign port.out_valid = req;
  assign port.out_data  = head;
  assign occupancy      = count;
  assign route_err      = route_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      route_err_q <= 1'b0;
    end else begin
      route_err_q <= route_err_d;
    end
  end

  a_onehot_req: assert property (@(posedge clk) disable iff (reset)
    $onehot0(port.out_valid));

endmodule

// File: tb/tb_router_input_port.sv
// tb/tb_router_input_port.sv - self-checking bench for router_input_port
// Two instances at (1,1): default widths (a) and COORD_W=3 for out-of-mesh drops (b).
module tb_router_input_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_err, b_err;
  logic [2:0] a_occ, b_occ;

  router_input_port_if #(.FLIT_W(11)) a_if ();
  router_input_port_if #(.FLIT_W(13)) b_if ();

  router_input_port #(.MY_X(1), .MY_Y(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .port      (a_if.slave),
    .route_err (a_err),
    .occupancy (a_occ)
  );

  router_input_port #(.MY_X(1), .MY_Y(1), .COORD_W(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .port      (b_if.slave),
    .route_err (b_err),
    .occupancy (b_occ)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int misses  = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference routing at (1,1) in a 4x4 mesh: -1 = drop, else direction index
  function automatic int model_dir(input int x, input int y);
    if (x >= 4 || y >= 4) return -1;
    if (x > 1) return 1;
    if (x < 1) return 3;
    if (y > 1) return 0;
    if (y < 1) return 2;
    return 4;
  endfunction

  function automatic logic [10:0] mk_a(input logic [1:0] x, input logic [1:0] y, input logic [6:0] p);
    return {x, y, p};
  endfunction

  function automatic logic [12:0] mk_b(input logic [2:0] x, input logic [2:0] y, input logic [6:0] p);
    return {x, y, p};
  endfunction

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit ea = 0, eb = 0, model_ok = 0;

  always @(posedge clk) begin
    logic [15:0] h;
    int d;
    bit pop, push;
    if (reset) begin
      qa.delete();
      qb.delete();
      ea = 0;
      eb = 0;
      model_ok = 1;
    end else begin
      pop = 0;
      if (qa.size() > 0) begin
        h = qa[0];
        d = model_dir(int'(h[10:9]), int'(h[8:7]));
        if (d < 0) begin pop = 1; ea = 1; end
        else if (a_if.out_ready[d]) pop = 1;
      end
      push = a_if.in_valid && qa.size() < 4;
      if (pop) void'(qa.pop_front());
      if (push) qa.push_back(16'(a_if.in_data));

      pop = 0;
      if (qb.size() > 0) begin
        h = qb[0];
        d = model_dir(int'(h[12:10]), int'(h[9:7]));
        if (d < 0) begin pop = 1; eb = 1; end
        else if (b_if.out_ready[d]) pop = 1;
      end
      push = b_if.in_valid && qb.size() < 4;
      if (pop) void'(qb.pop_front());
      if (push) qb.push_back(16'(b_if.in_data));
    end
  end

  always @(negedge clk) begin
    logic [15:0] h;
    logic [4:0]  ev;
    int d;
    if (model_ok) begin
      ev = '0;
      h  = '0;
      if (qa.size() > 0) begin
        h = qa[0];
        d = model_dir(int'(h[10:9]), int'(h[8:7]));
        if (d >= 0) ev = 5'(1 << d);
      end
      cmp("a_out_valid", 32'(a_if.out_valid), 32'(ev));
      cmp("a_in_ready", 32'(a_if.in_ready), 32'(qa.size() < 4));
      cmp("a_occupancy", 32'(a_occ), 32'(qa.size()));
      cmp("a_route_err", 32'(a_err), 32'(ea));
      if (ev != 0) cmp("a_out_data", 32'(a_if.out_data), 32'(h[10:0]));

      ev = '0;
      h  = '0;
      if (qb.size() > 0) begin
        h = qb[0];
        d = model_dir(int'(h[12:10]), int'(h[9:7]));
        if (d >= 0) ev = 5'(1 << d);
      end
      cmp("b_out_valid", 32'(b_if.out_valid), 32'(ev));
      cmp("b_in_ready", 32'(b_if.in_ready), 32'(qb.size() < 4));
      cmp("b_occupancy", 32'(b_occ), 32'(qb.size()));
      cmp("b_route_err", 32'(b_err), 32'(eb));
      if (ev != 0) cmp("b_out_data", 32'(b_if.out_data), 32'(h[12:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          tx [4] = '{1, 1, 0, 1};
  int          ty [4] = '{3, 0, 2, 1};
  logic [4:0]  tv [4] = '{5'b00001, 5'b00100, 5'b01000, 5'b10000};

  initial begin
    reset = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = '0;
    step();
    step();
    cmp("rst_in_ready", 32'(a_if.in_ready), 32'd1);
    cmp("rst_occupancy", 32'(a_occ), 32'd0);
    cmp("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    reset = 1'b0;

    // single flit to (3,1): east, one cycle latency
    a_if.out_ready = 5'b11111;
    a_if.in_valid  = 1'b1;
    a_if.in_data   = mk_a(2'd3, 2'd1, 7'h2A);
    step();
    a_if.in_valid = 1'b0;
    cmp("t1_out_valid", 32'(a_if.out_valid), 32'h02);
    cmp("t1_out_data", 32'(a_if.out_data), 32'h6AA);
    step();
    cmp("t1_empty", 32'(a_occ), 32'd0);
    cmp("t1_idle", 32'(a_if.out_valid), 32'd0);

    // back-to-back N,S,W,L
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = mk_a(2'(tx[i]), 2'(ty[i]), 7'(16 + i));
      step();
      cmp("t2_out_valid", 32'(a_if.out_valid), 32'(tv[i]));
      cmp("t2_out_data", 32'(a_if.out_data), 32'(mk_a(2'(tx[i]), 2'(ty[i]), 7'(16 + i))));
    end
    a_if.in_valid = 1'b0;
    step();

    // backpressure: fifth push refused, then ordered drain
    a_if.out_ready = '0;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_if.in_data = mk_a(2'd3, 2'd1, 7'(i + 1));
      step();
    end
    cmp("t3_occupancy", 32'(a_occ), 32'd4);
    cmp("t3_in_ready", 32'(a_if.in_ready), 32'd0);
    cmp("t3_head", 32'(a_if.out_data), 32'(mk_a(2'd3, 2'd1, 7'd1)));
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) step();
    cmp("t3_drained", 32'(a_occ), 32'd0);

    // full FIFO: pop and push in the same cycle, push must wait
    a_if.out_ready = '0;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_if.in_data = mk_a(2'd3, 2'd1, 7'(10 + i));
      step();
    end
    a_if.out_ready = 5'b00010;
    a_if.in_data   = mk_a(2'd3, 2'd1, 7'd14);
    step();
    cmp("t4_occ_after_pop", 32'(a_occ), 32'd3);
    cmp("t4_in_ready", 32'(a_if.in_ready), 32'd1);
    cmp("t4_head", 32'(a_if.out_data), 32'(mk_a(2'd3, 2'd1, 7'd11)));
    a_if.out_ready = '0;
    step();
    cmp("t4_refilled", 32'(a_occ), 32'd4);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 5'b11111;
    for (int i = 0; i < 4; i++) step();
    cmp("t4_drained", 32'(a_occ), 32'd0);

    // out-of-mesh destination dropped, next flit ejects locally
    b_if.out_ready = 5'b11111;
    b_if.in_valid  = 1'b1;
    b_if.in_data   = mk_b(3'd5, 3'd0, 7'h11);
    step();
    cmp("t5_no_valid", 32'(b_if.out_valid), 32'd0);
    cmp("t5_err_not_yet", 32'(b_err), 32'd0);
    b_if.in_data = mk_b(3'd1, 3'd1, 7'h22);
    step();
    b_if.in_valid = 1'b0;
    cmp("t5_route_err", 32'(b_err), 32'd1);
    cmp("t5_local", 32'(b_if.out_valid), 32'h10);
    cmp("t5_data", 32'(b_if.out_data), 32'(mk_b(3'd1, 3'd1, 7'h22)));
    step();
    cmp("t5_empty", 32'(b_occ), 32'd0);

    // reset with three flits buffered; handshake in reset cycle ignored
    a_if.out_ready = '0;
    a_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.in_data = mk_a(2'd0, 2'd0, 7'(30 + i));
      step();
    end
    cmp("t6_buffered", 32'(a_occ), 32'd3);
    reset = 1'b1;
    step();
    cmp("t6_occupancy", 32'(a_occ), 32'd0);
    cmp("t6_out_valid", 32'(a_if.out_valid), 32'd0);
    cmp("t6_in_ready", 32'(a_if.in_ready), 32'd1);
    cmp("t6_route_err_b", 32'(b_err), 32'd0);
    reset = 1'b0;
    a_if.in_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
